// File: rtl/csr_int_unit_if.sv
// Bus bundle for csr_int_unit: interrupt/trap handshake plus CSR read/write port.
// The control side (master) drives requests; the interrupt unit (slave) returns trap state.
interface csr_int_unit_if;
    logic        INTR;
    logic        instr_done;
    logic        mret_exec;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wd;
    logic [31:0] pc;
    logic        int_taken;
    logic [31:0] csr_rd;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        mie_o;
    logic        intr_pending;

    modport master (
        output INTR, instr_done, mret_exec, csr_we, csr_addr, csr_wd, pc,
        input  int_taken, csr_rd, mtvec, mepc, mie_o, intr_pending
    );

    modport slave (
        input  INTR, instr_done, mret_exec, csr_we, csr_addr, csr_wd, pc,
        output int_taken, csr_rd, mtvec, mepc, mie_o, intr_pending
    );
endinterface

// File: rtl/csr_int_unit.sv
// Machine-mode interrupt unit: mstatus/mtvec/mepc/mcause CSRs, synchronised external
// interrupt with edge detect, and a RUN/TRAP/HANDLER trap-entry state machine.
module csr_int_unit (
    input  logic           CLK,
    input  logic           RST_N,
    csr_int_unit_if.slave  bus
);
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    localparam logic [31:0] MSTATUS_MASK = 32'h0000_0088;
    localparam logic [31:0] MSTATUS_MIE  = 32'h0000_0008;
    localparam logic [31:0] MSTATUS_MPIE = 32'h0000_0080;
    localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;
    localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;

    typedef enum logic [1:0] {RUN, TRAP, HANDLER} state_t;

    state_t      state;
    logic        run_en;
    logic        sync1, sync2, sync_prev;
    logic        intr_rise;
    logic        intr_pending_q;
    logic        int_taken_q;
    logic [31:0] mstatus_q;
    logic [31:0] mtvec_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic        mie;
    logic        mpie;
    logic        trap_entry;
    logic        mret_ok;
    logic        wr_mstatus;
    logic        wr_mtvec;
    logic        wr_mepc;

    assign mie        = mstatus_q[3];
    assign mpie       = mstatus_q[7];
    assign intr_rise  = sync2 & ~sync_prev;
    assign trap_entry = (state == RUN) & bus.instr_done & intr_pending_q & mie;
    assign mret_ok    = bus.mret_exec & (state != TRAP);
    assign wr_mstatus = bus.csr_we & (bus.csr_addr == ADDR_MSTATUS);
    assign wr_mtvec   = bus.csr_we & (bus.csr_addr == ADDR_MTVEC);
    assign wr_mepc    = bus.csr_we & (bus.csr_addr == ADDR_MEPC);

    // Reset release is retimed by one flop so the first update lands on the second edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            run_en <= 1'b0;
        end else begin
            run_en <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state          <= RUN;
            sync1          <= 1'b0;
            sync2          <= 1'b0;
            sync_prev      <= 1'b0;
            intr_pending_q <= 1'b0;
            int_taken_q    <= 1'b0;
            mstatus_q      <= '0;
            mtvec_q        <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
        end else if (run_en) begin
            sync1     <= bus.INTR;
            sync2     <= sync1;
            sync_prev <= sync2;

            int_taken_q <= 1'b0;
            case (state)
                RUN: begin
                    if (trap_entry) begin
                        state       <= TRAP;
                        int_taken_q <= 1'b1;
                    end
                end
                TRAP:    state <= HANDLER;
                HANDLER: if (bus.mret_exec) state <= RUN;
                default: state <= RUN;
            endcase

            // A new edge wins over the clear so a request arriving at trap entry is kept.
            if (intr_rise) begin
                intr_pending_q <= 1'b1;
            end else if (trap_entry) begin
                intr_pending_q <= 1'b0;
            end

            if (trap_entry) begin
                mstatus_q <= mie ? MSTATUS_MPIE : '0;
            end else if (mret_ok) begin
                mstatus_q <= MSTATUS_MPIE | (mpie ? MSTATUS_MIE : '0);
            end else if (wr_mstatus) begin
                mstatus_q <= bus.csr_wd & MSTATUS_MASK;
            end

            if (trap_entry) begin
                mepc_q <= bus.pc & ALIGN_MASK;
            end else if (wr_mepc) begin
                mepc_q <= bus.csr_wd & ALIGN_MASK;
            end

            if (wr_mtvec) begin
                mtvec_q <= bus.csr_wd & ALIGN_MASK;
            end

            if (trap_entry) begin
                mcause_q <= CAUSE_EXT;
            end
        end
    end

    always_comb begin
        bus.csr_rd = '0;
        case (bus.csr_addr)
            ADDR_MSTATUS: bus.csr_rd = mstatus_q;
            ADDR_MTVEC:   bus.csr_rd = mtvec_q;
            ADDR_MEPC:    bus.csr_rd = mepc_q;
            ADDR_MCAUSE:  bus.csr_rd = mcause_q;
            default:      bus.csr_rd = '0;
        endcase
    end

    assign bus.int_taken    = int_taken_q;
    assign bus.mtvec        = mtvec_q;
    assign bus.mepc         = mepc_q;
    assign bus.mie_o        = mie;
    assign bus.intr_pending = intr_pending_q;
endmodule

// File: tb/tb_csr_int_unit.sv
// Directed scoreboard bench for csr_int_unit: expected values are queued as stimulus
// is applied and popped when the corresponding DUT output is sampled.
module tb_csr_int_unit;
    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_entry_t;

    logic      clk;
    logic      rst_n;
    sb_entry_t sb_q[$];
    int        n_tests;
    int        n_fail;

    csr_int_unit_if bus ();

    csr_int_unit dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running, required done");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic observe(input logic [31:0] obs);
        sb_entry_t e;
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h, required a queued expectation", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h required %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] exp, input logic [31:0] obs);
        expect_val(tag, exp);
        observe(obs);
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] wd);
        bus.csr_we   = 1'b1;
        bus.csr_addr = addr;
        bus.csr_wd   = wd;
        tick();
        bus.csr_we   = 1'b0;
    endtask

    task automatic csr_read(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        expect_val(tag, exp);
        bus.csr_addr = addr;
        #1;
        observe(bus.csr_rd);
    endtask

    task automatic intr_pulse();
        bus.INTR = 1'b1;
        tick();
        bus.INTR = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        bus.INTR       = 1'b0;
        bus.instr_done = 1'b0;
        bus.mret_exec  = 1'b0;
        bus.csr_we     = 1'b0;
        bus.csr_addr   = '0;
        bus.csr_wd     = '0;
        bus.pc         = '0;

        tick();
        tick();
        chk("rst_int_taken", 32'd0, {31'd0, bus.int_taken});
        chk("rst_mtvec", 32'd0, bus.mtvec);
        chk("rst_mepc", 32'd0, bus.mepc);
        chk("rst_mie", 32'd0, {31'd0, bus.mie_o});
        chk("rst_pending", 32'd0, {31'd0, bus.intr_pending});
        rst_n = 1'b1;
        tick();
        tick();
        tick();

        // CSR setup and map
        csr_write(12'h305, 32'h0000_0103);
        csr_read("mtvec_rd", 12'h305, 32'h0000_0100);
        chk("mtvec_out", 32'h0000_0100, bus.mtvec);
        csr_write(12'h300, 32'hFFFF_FF77);
        csr_read("mstatus_mask", 12'h300, 32'h0000_0000);
        csr_write(12'h300, 32'h0000_0088);
        csr_read("mstatus_rd", 12'h300, 32'h0000_0088);
        csr_write(12'h342, 32'h1234_5678);
        csr_read("mcause_ro", 12'h342, 32'h0000_0000);
        csr_write(12'h7C0, 32'hDEAD_BEEF);
        csr_read("unmapped_rd", 12'h7C0, 32'h0000_0000);
        csr_write(12'h341, 32'h0000_0123);
        csr_read("mepc_align", 12'h341, 32'h0000_0120);

        // Trap entry with synchroniser latency
        bus.pc   = 32'h0000_0044;
        bus.INTR = 1'b1;
        tick();
        bus.INTR = 1'b0;
        tick();
        chk("pending_k1", 32'd0, {31'd0, bus.intr_pending});
        tick();
        chk("pending_k2", 32'd1, {31'd0, bus.intr_pending});
        bus.instr_done = 1'b1;
        tick();
        bus.instr_done = 1'b0;
        chk("trap_taken", 32'd1, {31'd0, bus.int_taken});
        chk("trap_mepc", 32'h0000_0044, bus.mepc);
        chk("trap_pending_clr", 32'd0, {31'd0, bus.intr_pending});
        csr_read("trap_mcause", 12'h342, 32'h8000_000B);
        csr_read("trap_mstatus", 12'h300, 32'h0000_0080);
        tick();
        chk("handler_no_taken", 32'd0, {31'd0, bus.int_taken});
        bus.mret_exec = 1'b1;
        tick();
        bus.mret_exec = 1'b0;
        csr_read("mret_mstatus", 12'h300, 32'h0000_0088);

        // Masked interrupt stays pending
        csr_write(12'h300, 32'h0000_0000);
        intr_pulse();
        bus.instr_done = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            chk("masked_no_taken", 32'd0, {31'd0, bus.int_taken});
        end
        bus.instr_done = 1'b0;
        chk("masked_pending", 32'd1, {31'd0, bus.intr_pending});
        csr_write(12'h300, 32'h0000_0008);
        bus.instr_done = 1'b1;
        tick();
        bus.instr_done = 1'b0;
        chk("unmask_taken", 32'd1, {31'd0, bus.int_taken});
        csr_read("unmask_mstatus", 12'h300, 32'h0000_0080);

        // mret during TRAP ignored, nested request in HANDLER
        bus.mret_exec = 1'b1;
        tick();
        bus.mret_exec = 1'b0;
        chk("mret_in_trap_mie", 32'd0, {31'd0, bus.mie_o});
        chk("trap_one_cycle", 32'd0, {31'd0, bus.int_taken});
        intr_pulse();
        chk("nested_pending", 32'd1, {31'd0, bus.intr_pending});
        bus.instr_done = 1'b1;
        tick();
        bus.instr_done = 1'b0;
        chk("handler_instr_done", 32'd0, {31'd0, bus.int_taken});
        bus.mret_exec = 1'b1;
        tick();
        bus.mret_exec = 1'b0;
        chk("nested_mret_mie", 32'd1, {31'd0, bus.mie_o});
        bus.instr_done = 1'b1;
        tick();
        bus.instr_done = 1'b0;
        chk("nested_taken", 32'd1, {31'd0, bus.int_taken});
        tick();
        bus.mret_exec = 1'b1;
        tick();
        bus.mret_exec = 1'b0;

        // Collisions: trap entry beats CSR writes to mepc and mstatus
        intr_pulse();
        bus.pc         = 32'h0000_004B;
        bus.instr_done = 1'b1;
        csr_write(12'h341, 32'h0000_0200);
        bus.instr_done = 1'b0;
        chk("coll_taken", 32'd1, {31'd0, bus.int_taken});
        chk("coll_mepc", 32'h0000_0048, bus.mepc);
        tick();
        bus.mret_exec = 1'b1;
        tick();
        bus.mret_exec = 1'b0;
        intr_pulse();
        bus.instr_done = 1'b1;
        csr_write(12'h300, 32'h0000_0008);
        bus.instr_done = 1'b0;
        chk("coll_mie", 32'd0, {31'd0, bus.mie_o});
        csr_read("coll_mstatus", 12'h300, 32'h0000_0080);
        tick();
        bus.mret_exec = 1'b1;
        tick();
        bus.mret_exec = 1'b0;

        // mret in RUN applies the MIE/MPIE update
        csr_write(12'h300, 32'h0000_0000);
        bus.mret_exec = 1'b1;
        tick();
        bus.mret_exec = 1'b0;
        csr_read("mret_run_mstatus", 12'h300, 32'h0000_0080);
        chk("mret_run_no_taken", 32'd0, {31'd0, bus.int_taken});

        // New edge on the trap-entry edge keeps intr_pending set
        csr_write(12'h300, 32'h0000_0008);
        intr_pulse();
        bus.INTR = 1'b1;
        tick();
        bus.INTR = 1'b0;
        tick();
        bus.instr_done = 1'b1;
        tick();
        bus.instr_done = 1'b0;
        chk("race_taken", 32'd1, {31'd0, bus.int_taken});
        chk("race_pending", 32'd1, {31'd0, bus.intr_pending});
        tick();
        chk("handler_pending", 32'd1, {31'd0, bus.intr_pending});

        // Asynchronous reset in HANDLER with a pending request
        bus.csr_addr = 12'h341;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_int_taken", 32'd0, {31'd0, bus.int_taken});
        chk("arst_mtvec", 32'd0, bus.mtvec);
        chk("arst_mepc", 32'd0, bus.mepc);
        chk("arst_mie", 32'd0, {31'd0, bus.mie_o});
        chk("arst_pending", 32'd0, {31'd0, bus.intr_pending});
        chk("arst_csr_rd_mepc", 32'd0, bus.csr_rd);
        csr_read("arst_mcause", 12'h342, 32'd0);
        tick();
        tick();

        // Release: first update on the second edge
        rst_n        = 1'b1;
        bus.csr_we   = 1'b1;
        bus.csr_addr = 12'h305;
        bus.csr_wd   = 32'h0000_0010;
        tick();
        chk("release_edge1", 32'd0, bus.mtvec);
        tick();
        bus.csr_we = 1'b0;
        chk("release_edge2", 32'h0000_0010, bus.mtvec);

        // Back in RUN with nothing pending
        csr_write(12'h300, 32'h0000_0008);
        bus.instr_done = 1'b1;
        tick();
        bus.instr_done = 1'b0;
        chk("post_rst_no_taken", 32'd0, {31'd0, bus.int_taken});
        intr_pulse();
        bus.instr_done = 1'b1;
        tick();
        bus.instr_done = 1'b0;
        chk("post_rst_taken", 32'd1, {31'd0, bus.int_taken});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/csr_int_unit.md
CSR_INT_UNIT -- requirements
Module: csr_int_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; ports are listed in REQ-002 to REQ-015.
REQ-002 CLK  in  1  system clock; all state changes on the rising edge.
REQ-003 RST_N  in  1  reset; asynchronous, active-low.
REQ-004 INTR  in  1  external interrupt request; asynchronous level.
REQ-005 instr_done  in  1  one-cycle pulse from the control FSM at the final cycle of each instruction.
REQ-006 mret_exec  in  1  one-cycle pulse when an mret instruction executes.
REQ-007 csr_we  in  1  CSR write strobe.
REQ-008 csr_addr  in  12  CSR address for read and write.
REQ-009 csr_wd  in  32  CSR write data.
REQ-010 pc  in  32  address of the next instruction to resume at.
REQ-011 int_taken  out  1  trap-entry pulse to the decoder and FSM.
REQ-012 csr_rd  out  32  combinational read data for csr_addr.
REQ-013 mtvec  out  32  trap vector.
REQ-014 mepc  out  32  return address.
REQ-015 mie_o  out  1  mstatus.MIE; intr_pending out 1 latched request.

Function
REQ-016 The CSR map SHALL be:
- mstatus 0x300: bit3 MIE, bit7 MPIE, all other bits read 0.
- mtvec 0x305
- mepc 0x341
- mcause 0x342, read-only.
REQ-017 A read of any other csr_addr SHALL return 0, and a write to it SHALL be ignored.
REQ-018 Writes to mtvec and mepc SHALL force bits[1:0] to 0.
REQ-019 The mstatus write SHALL update only MIE (csr_wd[3]) and MPIE (csr_wd[7]).
REQ-020 INTR SHALL pass through a 2-flop synchronizer followed by a rising-edge detector.
REQ-021 INTR high first sampled at edge k SHALL set intr_pending after edge k+2.
REQ-022 intr_pending SHALL hold until trap entry; further INTR edges while it is set are absorbed.
REQ-023 The FSM states SHALL be RUN, TRAP and HANDLER.
REQ-024 RUN SHALL move to TRAP when instr_done=1, intr_pending=1 and MIE=1, all sampled at the same edge.
REQ-025 On the RUN to TRAP edge:
- mepc <= {pc[31:2],2'b00}
- MPIE <= MIE, MIE <= 0
- mcause <= 32'h8000000B
- intr_pending <= 0
REQ-026 TRAP SHALL last exactly one cycle with int_taken=1 and then go to HANDLER; int_taken SHALL be 0 in every other state.
REQ-027 HANDLER SHALL move to RUN on mret_exec, with MIE <= MPIE and MPIE <= 1.
REQ-028 mret_exec in RUN SHALL apply the same MIE/MPIE update and remain in RUN; mret_exec in TRAP SHALL be ignored.
REQ-029 An INTR edge during TRAP or HANDLER SHALL set intr_pending, and the trap SHALL be taken on the first qualifying instr_done after return to RUN.
REQ-030 Priority on the same edge SHALL be trap entry > mret > CSR write for mstatus and mepc; the losing CSR write is discarded.
REQ-031 A CSR write to mtvec or mcause-address SHALL never conflict with trap entry.
REQ-032 If a clearing write to intr_pending and a new detected edge occur on the same edge, intr_pending SHALL end at 1.
REQ-033 csr_rd SHALL reflect register state after the last edge, with no write-through bypass.

Reset
REQ-034 RST_N=0 SHALL, asynchronously:
- clear mtvec, mepc, mcause, MIE, MPIE, intr_pending, the synchronizer and edge flops, and int_taken to 0
- force state RUN
REQ-035 Reset asserted in any state, including TRAP or HANDLER, SHALL abandon the trap with no residual pending.
REQ-036 Deassertion SHALL be used synchronously, with the first state change on the second rising edge after RST_N rises.

Verification
REQ-037 Setup: write mtvec=0x00000103, then 0x305 -> mtvec=0x00000100. Write mstatus=0x88, then 0x300 -> reads 0x88.
REQ-038 Trap entry: MIE=1, pc=0x00000044, INTR pulse, wait 3 edges, instr_done -> int_taken for 1 cycle, mepc=0x44, mcause=0x8000000B, mstatus reads 0x80.
REQ-039 Masked interrupt: MIE=0, INTR pulse, instr_done x5 -> no int_taken, intr_pending=1. Then write mstatus=0x08 and instr_done -> int_taken.
REQ-040 Nested request: INTR during HANDLER, then mret_exec -> MIE=1, state RUN. Next instr_done -> second int_taken.
REQ-041 Collision: trap-entry edge together with csr_we to mepc=0x200 -> mepc=pc, not 0x200. Same edge with a write of mstatus=0x08 -> MIE=0.
REQ-042 Reset in HANDLER with intr_pending=1: pull RST_N low mid-cycle -> all outputs 0 immediately, state RUN, csr_rd(0x341)=0.
